// File: rtl/inst_line_cache.sv
// Direct-mapped read-only instruction cache. Hits answer the cycle after acceptance.
// Misses fetch one 4-word line from the AXI bridge. While a refill is in flight, addr_ok stays low.
module inst_line_cache #(
  parameter int SETS = 8
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        inst_sram_req,
  input  logic [31:0] inst_sram_addr,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  input  logic        inv_all,
  output logic        rd_req,
  output logic [2:0]  rd_type,
  output logic [31:0] rd_addr,
  input  logic        rd_rdy,
  input  logic        ret_valid,
  input  logic        ret_last,
  input  logic [31:0] ret_data,
  output logic        refill_err
);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 28 - IDX_W;

  typedef enum logic [2:0] {IDLE, LOOKUP, MISS, REFILL, RESP} state_t;

  state_t              state, state_nxt;
  logic [31:0]         req_addr;
  logic [1:0]          cnt;
  logic                inv_pending;
  logic [SETS-1:0]     valid;
  logic [TAG_W-1:0]    tags [SETS];
  logic [31:0]         data [SETS][4];

  logic [IDX_W-1:0]    idx;
  logic [TAG_W-1:0]    req_tag;
  logic [1:0]          word;
  logic                hit;
  logic                addr_ok_c;
  logic                last_beat;
  logic                unused_addr_lsb;

  assign idx             = req_addr[4+IDX_W-1:4];
  assign req_tag         = req_addr[31:4+IDX_W];
  assign word            = req_addr[3:2];
  assign unused_addr_lsb = ^req_addr[1:0];
  assign hit             = valid[idx] && (tags[idx] == req_tag);
  assign last_beat       = (state == REFILL) && ret_valid && ret_last;

  always_comb begin
    state_nxt       = state;
    addr_ok_c       = 1'b0;
    inst_sram_data_ok = 1'b0;
    inst_sram_rdata = 32'h0;
    rd_req          = 1'b0;
    refill_err      = 1'b0;
    case (state)
      IDLE: begin
        addr_ok_c = inst_sram_req;
        if (inst_sram_req) state_nxt = LOOKUP;
      end
      LOOKUP: begin
        if (hit) begin
          inst_sram_data_ok = 1'b1;
          inst_sram_rdata   = data[idx][word];
          addr_ok_c         = inst_sram_req;
          state_nxt         = inst_sram_req ? LOOKUP : IDLE;
        end else begin
          state_nxt = MISS;
        end
      end
      MISS: begin
        rd_req = 1'b1;
        if (rd_rdy) state_nxt = REFILL;
      end
      REFILL: begin
        if (last_beat) begin
          refill_err = (cnt != 2'd3);
          state_nxt  = RESP;
        end
      end
      RESP: begin
        inst_sram_data_ok = 1'b1;
        inst_sram_rdata   = data[idx][word];
        state_nxt         = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Reset forces IDLE, where only addr_ok could follow the request; gate it so reset silences every output.
  assign inst_sram_addr_ok = addr_ok_c & aresetn;
  assign rd_type           = 3'b100;
  assign rd_addr           = {req_addr[31:4], 4'b0};

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state       <= IDLE;
      req_addr    <= 32'h0;
      cnt         <= 2'd0;
      inv_pending <= 1'b0;
      valid       <= '0;
    end else begin
      state <= state_nxt;
      if (addr_ok_c) req_addr <= inst_sram_addr;

      if (state == MISS && rd_rdy)           cnt <= 2'd0;
      else if (state == REFILL && ret_valid) cnt <= cnt + 2'd1;

      if (last_beat)
        inv_pending <= 1'b0;
      else if (inv_all && (state == MISS || state == REFILL))
        inv_pending <= 1'b1;

      // The victim line is dropped at grant so a short (errored) refill never leaves stale words valid.
      if (inv_all) begin
        valid <= '0;
      end else begin
        if (state == MISS && rd_rdy) valid[idx] <= 1'b0;
        if (last_beat && cnt == 2'd3 && !inv_pending) valid[idx] <= 1'b1;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (state == REFILL && ret_valid) data[idx][cnt] <= ret_data;
    if (last_beat && cnt == 2'd3)     tags[idx]      <= req_tag;
  end

endmodule

// File: tb/tb_inst_line_cache.sv
// Directed bench for inst_line_cache; responses are scored by a negedge monitor against a queue.
module tb_inst_line_cache;
  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        inst_sram_req = 1'b0;
  logic [31:0] inst_sram_addr = 32'h0;
  logic        inst_sram_addr_ok, inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        inv_all = 1'b0;
  logic        rd_req;
  logic [2:0]  rd_type;
  logic [31:0] rd_addr;
  logic        rd_rdy = 1'b0;
  logic        ret_valid = 1'b0;
  logic        ret_last = 1'b0;
  logic [31:0] ret_data = 32'h0;
  logic        refill_err;

  always #5 aclk = ~aclk;

  inst_line_cache #(.SETS(8)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .inst_sram_req(inst_sram_req), .inst_sram_addr(inst_sram_addr),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata(inst_sram_rdata), .inv_all(inv_all),
    .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
    .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
    .refill_err(refill_err)
  );

  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_q[$];
  int          dok_cyc[$];
  int          cyc_n = 0;
  int          hs_cnt = 0;
  int          rdreq_cyc = 0;
  logic [31:0] mon_exp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  always @(posedge aclk) cyc_n++;

  always @(negedge aclk) begin
    if (aresetn) begin
      if (rd_req) rdreq_cyc++;
      if (rd_req && rd_rdy) hs_cnt++;
      if (inst_sram_data_ok) begin
        dok_cyc.push_back(cyc_n);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_data_ok: got %h want none", inst_sram_rdata);
        end else begin
          mon_exp = exp_q.pop_front();
          check("rdata", inst_sram_rdata, mon_exp);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge aclk);
    #1;
  endtask

  // Leaves req high so a following issue() forms a back-to-back stream.
  task automatic issue(input logic [31:0] a, input logic [31:0] e);
    bit ok;
    ok = 1'b0;
    exp_q.push_back(e);
    inst_sram_req  = 1'b1;
    inst_sram_addr = a;
    for (int n = 0; n < 50; n++) begin
      @(negedge aclk);
      if (inst_sram_addr_ok) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("addr_ok_timeout", 32'(ok), 32'd1);
    else     cyc();
  endtask

  task automatic fetch1(input logic [31:0] a, input logic [31:0] e);
    issue(a, e);
    inst_sram_req = 1'b0;
  endtask

  task automatic grant(input logic [31:0] a, input int stall);
    bit ok;
    int hs0;
    ok  = 1'b0;
    hs0 = hs_cnt;
    for (int n = 0; n < 50; n++) begin
      @(negedge aclk);
      if (rd_req) begin
        ok = 1'b1;
        break;
      end
    end
    check("rd_req_seen", 32'(ok), 32'd1);
    check("rd_addr", rd_addr, a);
    check("rd_type", 32'(rd_type), 32'd4);
    for (int s = 0; s < stall; s++) begin
      cyc();
      @(negedge aclk);
      check("stall_rd_req", 32'(rd_req), 32'd1);
      check("stall_rd_addr", rd_addr, a);
    end
    cyc();
    rd_rdy = 1'b1;
    cyc();
    rd_rdy = 1'b0;
    check("rd_handshakes", 32'(hs_cnt - hs0), 32'd1);
  endtask

  task automatic beats(input logic [31:0] d [4], input int last_beat, input int inv_beat);
    for (int i = 0; i < last_beat; i++) begin
      ret_valid = 1'b1;
      ret_data  = d[i];
      ret_last  = (i == last_beat - 1);
      inv_all   = (i + 1 == inv_beat);
      if (ret_last) begin
        @(negedge aclk);
        check("refill_err", 32'(refill_err), 32'(last_beat != 4));
      end
      cyc();
    end
    ret_valid = 1'b0;
    ret_last  = 1'b0;
    inv_all   = 1'b0;
  endtask

  task automatic refill(input logic [31:0] a, input logic [31:0] d [4],
                        input int last_beat, input int stall, input int inv_beat);
    grant(a, stall);
    beats(d, last_beat, inv_beat);
  endtask

  task automatic drain();
    for (int n = 0; n < 50; n++) begin
      if (exp_q.size() == 0) break;
      cyc();
    end
    check("drain_pending", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int rq0;
    // Reset state, with a request already pending
    inst_sram_req  = 1'b1;
    inst_sram_addr = 32'h1c000000;
    #2;
    check("rst_addr_ok", 32'(inst_sram_addr_ok), 32'd0);
    check("rst_data_ok", 32'(inst_sram_data_ok), 32'd0);
    check("rst_rd_req", 32'(rd_req), 32'd0);
    check("rst_refill_err", 32'(refill_err), 32'd0);
    check("rst_rd_type", 32'(rd_type), 32'd4);
    inst_sram_req = 1'b0;
    cyc(); cyc();
    aresetn = 1'b1;
    cyc();

    // Cold miss
    fetch1(32'h1c000000, 32'h11);
    refill(32'h1c000000, '{32'h11, 32'h22, 32'h33, 32'h44}, 4, 0, 0);
    drain();

    // Back-to-back hit stream
    rq0 = rdreq_cyc;
    dok_cyc.delete();
    issue(32'h1c000004, 32'h22);
    issue(32'h1c000008, 32'h33);
    issue(32'h1c00000c, 32'h44);
    inst_sram_req = 1'b0;
    drain();
    check("stream_no_rd_req", 32'(rdreq_cyc - rq0), 32'd0);
    check("stream_dok_count", 32'(dok_cyc.size()), 32'd3);
    if (dok_cyc.size() == 3)
      check("stream_consecutive", 32'(dok_cyc[2] - dok_cyc[0]), 32'd2);

    // Conflict miss on index 0, then a hit in the new line
    fetch1(32'h1c000080, 32'ha1);
    refill(32'h1c000080, '{32'ha1, 32'ha2, 32'ha3, 32'ha4}, 4, 0, 0);
    drain();
    rq0 = rdreq_cyc;
    fetch1(32'h1c000084, 32'ha2);
    drain();
    check("conflict_hit_no_rd", 32'(rdreq_cyc - rq0), 32'd0);

    // Old line evicted; refetch misses, with the bridge stalling 5 cycles
    fetch1(32'h1c000008, 32'h53);
    refill(32'h1c000000, '{32'h51, 32'h52, 32'h53, 32'h54}, 4, 5, 0);
    drain();

    // Invalidate on the 2nd beat: fetch completes, line stays invalid
    fetch1(32'h1c000114, 32'h62);
    refill(32'h1c000110, '{32'h61, 32'h62, 32'h63, 32'h64}, 4, 0, 2);
    drain();
    fetch1(32'h1c000114, 32'h72);
    refill(32'h1c000110, '{32'h71, 32'h72, 32'h73, 32'h74}, 4, 0, 0);
    drain();

    // Invalidate while idle: both filled lines miss afterwards
    inv_all = 1'b1;
    cyc();
    inv_all = 1'b0;
    cyc();
    fetch1(32'h1c000004, 32'h82);
    refill(32'h1c000000, '{32'h81, 32'h82, 32'h83, 32'h84}, 4, 0, 0);
    drain();
    fetch1(32'h1c000118, 32'h93);
    refill(32'h1c000110, '{32'h91, 32'h92, 32'h93, 32'h94}, 4, 0, 0);
    drain();

    // Early ret_last: error pulse, one response, line left invalid
    fetch1(32'h1c000020, 32'he1);
    refill(32'h1c000020, '{32'he1, 32'he2, 32'h0, 32'h0}, 2, 0, 0);
    drain();
    fetch1(32'h1c000020, 32'hf1);
    refill(32'h1c000020, '{32'hf1, 32'hf2, 32'hf3, 32'hf4}, 4, 0, 0);
    drain();

    // Reset in the middle of a refill
    fetch1(32'h1c000030, 32'h0);
    grant(32'h1c000030, 0);
    ret_valid = 1'b1;
    ret_data  = 32'hd1;
    cyc();
    ret_data  = 32'hd2;
    cyc();
    ret_valid = 1'b0;
    inst_sram_req = 1'b1;
    aresetn = 1'b0;
    #1;
    check("midrst_addr_ok", 32'(inst_sram_addr_ok), 32'd0);
    check("midrst_data_ok", 32'(inst_sram_data_ok), 32'd0);
    check("midrst_rdata", inst_sram_rdata, 32'h0);
    check("midrst_rd_req", 32'(rd_req), 32'd0);
    check("midrst_rd_addr", rd_addr, 32'h0);
    check("midrst_refill_err", 32'(refill_err), 32'd0);
    inst_sram_req = 1'b0;
    exp_q.delete();
    cyc();
    aresetn = 1'b1;
    cyc();
    fetch1(32'h1c000000, 32'hc1);
    refill(32'h1c000000, '{32'hc1, 32'hc2, 32'hc3, 32'hc4}, 4, 0, 0);
    drain();

    cyc(); cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/inst_line_cache.md
Name: inst_line_cache

Overview:
- Small direct-mapped, read-only instruction cache between the IF stage's sram-like fetch port and the AXI bridge's icache read port.
- Hits return in one cycle after address acceptance.
- Misses issue one 4-word line read (rd_type 3'b100) to the bridge and fill the line from the returned beats.
- Includes a whole-cache invalidate for ibar/cacop-style flushes.

Parameters:
- SETS, 8, number of lines; power of two, 2..64.
- IDX_W, $clog2(SETS), index width (derived, not overridden).

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- inst_sram_req  in  1  fetch request valid
- inst_sram_addr  in  32  fetch byte address (word aligned)
- inst_sram_addr_ok  out  1  request accepted this cycle
- inst_sram_data_ok  out  1  instruction valid this cycle
- inst_sram_rdata  out  32  instruction word
- inv_all  in  1  one-cycle pulse: invalidate every line
- rd_req  out  1  line read request to bridge
- rd_type  out  3  constant 3'b100 (cache line)
- rd_addr  out  32  line-aligned address, {tag,index,4'b0}
- rd_rdy  in  1  bridge accepts rd_req
- ret_valid  in  1  returned beat valid
- ret_last  in  1  final beat of line
- ret_data  in  32  returned beat data
- refill_err  out  1  one-cycle pulse: ret_last on a beat other than the 4th

Behaviour:
- Reset: aresetn low clears all valid bits, state to IDLE, beat counter to 0, and all outputs to 0 (rd_type stays constant 3'b100). Reset takes effect immediately, even mid-refill.
- Address split:
  - offset = addr[3:0], word = addr[3:2].
  - index = addr[4+IDX_W-1:4].
  - tag = addr[31:4+IDX_W].
- Storage per line: valid bit, tag, 4x32 data words, all in flops.
- States: IDLE, LOOKUP, MISS, REFILL, RESP.
- addr_ok = inst_sram_req & (IDLE | (LOOKUP & hit)). On acceptance, the address is registered into req_addr.
- IDLE: go to LOOKUP on acceptance, else stay.
- LOOKUP:
  - hit = valid[idx] & tag match.
  - On hit: data_ok=1 and rdata=line word (combinational from flops). Next state is LOOKUP if a new request is accepted this same cycle, else IDLE. Back-to-back hits therefore sustain one fetch per cycle.
  - On miss: data_ok=0, addr_ok=0, go to MISS.
- MISS: rd_req=1 with rd_addr from req_addr. Hold rd_req and rd_addr stable until rd_req & rd_rdy; then clear beat counter and go to REFILL.
- REFILL:
  - rd_req=0. Each ret_valid writes ret_data into data[idx][cnt], then cnt increments (2-bit).
  - On the beat with ret_valid & ret_last: if cnt==3, set tag[idx]; set valid[idx] unless an invalidate is pending (see below). Go to RESP.
  - If ret_last arrives with cnt!=3: pulse refill_err, leave valid[idx]=0, go to RESP. The returned word is then whatever was written (undefined).
- RESP: data_ok=1 with rdata=data[idx][word] (the freshly written line), addr_ok=0, next IDLE. Exactly one data_ok per accepted request; responses in order.
- inv_all:
  - In IDLE, LOOKUP or RESP: clears all valid bits on the next edge. A LOOKUP in that same cycle still uses pre-clear valid.
  - In MISS or REFILL: sets inv_pending. All valid bits clear immediately, and the in-flight line is not marked valid on completion; the fetch itself still completes via RESP. inv_pending clears on leaving REFILL.
- ret_valid outside REFILL is ignored. rd_rdy outside MISS is ignored.
- A refill in progress cannot be cancelled except by reset. The CPU must keep inst_sram_req low or tolerate addr_ok=0 until RESP completes.

Test Plan:
- Cold miss: reset, fetch 0x1c000000.
  - rd_req with rd_addr=0x1c000000 and rd_type=3'b100 the cycle after LOOKUP.
  - Return beats 0x11,0x22,0x33,0x44 (ret_last on 4th) -> one data_ok with rdata=0x11.
- Hit stream after that fill: fetch 0x1c000004, then 0x1c000008, then 0x1c00000c on consecutive cycles -> addr_ok every cycle, data_ok on three consecutive cycles with 0x22, 0x33, 0x44, and no rd_req.
- Conflict miss: with SETS=8, fetch 0x1c000080 (same index 0, different tag) -> refill issued and line replaced. A refetch of 0x1c000000 then misses again.
- Stall handshake: hold rd_rdy=0 for 5 cycles in MISS -> rd_req and rd_addr stable all 5 cycles, with exactly one accepted request.
- Invalidate during refill: pulse inv_all on the 2nd returned beat -> fetch completes with the correct word, but the next access to the same address misses. Also invalidate in IDLE -> all lines miss afterwards.
- Error and reset:
  - ret_last on 2nd beat -> refill_err pulse, data_ok once, line invalid.
  - Assert aresetn=0 mid-REFILL -> outputs immediately 0, and after release the first fetch misses.
